// File: rtl/keccak_pkg.sv
// Shared Keccak state geometry and types for the lane loader / unloader pair.
package keccak_pkg;

  localparam int LANE_W     = 64;
  localparam int NUM_LANES  = 25;
  localparam int STATE_W    = LANE_W * NUM_LANES;
  localparam int LANE_IDX_W = 5;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

endpackage

// File: rtl/keccak_state_piso.sv
// Parallel-in/serial-out unloader for the Keccak state. The whole state is
// captured in one cycle, then streamed out as lanes with valid/ready
// handshaking, lane 0 (state[LANE_W-1:0]) first. The lane count is chosen per
// unload so the same block can emit a short digest or the full state.
module keccak_state_piso
  import keccak_pkg::*;
#(
  parameter int   LANE_W    = 64,
  parameter int   NUM_LANES = 25,
  localparam int  STATE_W   = LANE_W * NUM_LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STATE_W-1:0]    state_in,
  input  logic                  load,
  input  logic [LANE_IDX_W-1:0] num_lanes,
  output logic                  in_ready,
  output logic [LANE_W-1:0]     lane_out,
  output logic                  lane_valid,
  input  logic                  lane_ready,
  output logic                  lane_last,
  output logic [LANE_IDX_W-1:0] lane_idx,
  output logic                  done
);

  // A requested count of zero, or anything beyond the state size, means
  // "the whole state".
  function automatic lane_idx_t eff_num(input lane_idx_t n);
    if ((n == '0) || (int'(n) > NUM_LANES)) begin
      return lane_idx_t'(NUM_LANES);
    end
    return n;
  endfunction

  piso_state_t       state;
  logic [STATE_W-1:0] shift_reg;
  lane_idx_t         lanes_left;
  lane_idx_t         idx_q;
  logic              valid_q;
  logic              done_q;

  logic load_acc;
  logic beat_acc;
  logic last_beat;

  assign load_acc  = load && (state == IDLE);
  assign beat_acc  = valid_q && lane_ready;
  assign last_beat = (lanes_left == lane_idx_t'(1));

  // Handshake outputs derived directly from the registered state; the lane
  // itself is always the bottom of the shift register so a stalled beat
  // stays put without extra holding logic.
  always_comb begin
    in_ready   = (state == IDLE);
    lane_last  = valid_q && last_beat;
    lane_out   = shift_reg[LANE_W-1:0];
    lane_valid = valid_q;
    lane_idx   = idx_q;
    done       = done_q;
  end

  // Unload FSM together with the shift register and beat counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      lanes_left <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_acc) begin
            shift_reg  <= state_in;
            lanes_left <= eff_num(num_lanes);
            idx_q      <= '0;
            valid_q    <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (beat_acc) begin
            if (last_beat) begin
              // Final beat taken: drop back to IDLE with a clean register so
              // no stale state lingers on lane_out.
              shift_reg  <= '0;
              lanes_left <= '0;
              idx_q      <= '0;
              valid_q    <= 1'b0;
              done_q     <= 1'b1;
              state      <= IDLE;
            end else begin
              shift_reg  <= {{LANE_W{1'b0}}, shift_reg[STATE_W-1:LANE_W]};
              lanes_left <= lanes_left - lane_idx_t'(1);
              idx_q      <= idx_q + lane_idx_t'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
